orbit_step_ctrl: RTL and testbench

- Micro-sequencer that runs N semi-implicit Euler steps of the orbital integrator on one shared floating-point ALU (ADD/SUB/MUL/INVSQRT) and an external 16-entry state register file.
- Replaces the fully parallel multiplier/adder datapath.
- Issues one ALU operation at a time over a valid/ready handshake, waits for the result, then commands the register-file write.
- Sits between the host/display logic (start, step count, position strobe) and the ALU plus register file.

---
 rtl/orbit_step_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_orbit_step_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orbit_step_ctrl.sv
// orbit_step_ctrl: micro-sequencer that drives one shared FP ALU and a
// 16-entry state register file through N semi-implicit Euler steps.
// One ALU op is in flight at a time: ISSUE -> WAIT -> WRITE, 17 ops per step.
module orbit_step_ctrl #(
  parameter int STEP_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [1:0]        op_code,
  output logic [3:0]        op_a,
  output logic [3:0]        op_b,
  input  logic              res_valid,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [STEP_W-1:0] step_idx,
  output logic              pos_strobe
);

  localparam logic [1:0]        OP_ADD   = 2'd0;
  localparam logic [1:0]        OP_SUB   = 2'd1;
  localparam logic [1:0]        OP_MUL   = 2'd2;
  localparam logic [1:0]        OP_ISQ   = 2'd3;
  localparam logic [4:0]        LAST_PC  = 5'd16;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT     = 3'd2,
    S_WRITE    = 3'd3,
    S_STEP_END = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] dst;
    logic [3:0] a;
    logic [3:0] b;
  } instr_t;

  // One Euler step: r2 = x^2+y^2, inv = GM/r^3, a = -inv*pos (folded into SUB),
  // velocity update first, then position uses the new velocity.
  function automatic instr_t prog_rom(input logic [4:0] pc);
    instr_t ins;
    case (pc)
      5'd0:    ins = {OP_MUL, 4'd5,  4'd0, 4'd0};
      5'd1:    ins = {OP_MUL, 4'd11, 4'd1, 4'd1};
      5'd2:    ins = {OP_ADD, 4'd4,  4'd5, 4'd11};
      5'd3:    ins = {OP_ISQ, 4'd6,  4'd4, 4'd4};
      5'd4:    ins = {OP_MUL, 4'd5,  4'd6, 4'd6};
      5'd5:    ins = {OP_MUL, 4'd6,  4'd5, 4'd6};
      5'd6:    ins = {OP_MUL, 4'd5,  4'd6, 4'd9};
      5'd7:    ins = {OP_MUL, 4'd7,  4'd0, 4'd5};
      5'd8:    ins = {OP_MUL, 4'd8,  4'd1, 4'd5};
      5'd9:    ins = {OP_MUL, 4'd11, 4'd7, 4'd10};
      5'd10:   ins = {OP_SUB, 4'd2,  4'd2, 4'd11};
      5'd11:   ins = {OP_MUL, 4'd11, 4'd8, 4'd10};
      5'd12:   ins = {OP_SUB, 4'd3,  4'd3, 4'd11};
      5'd13:   ins = {OP_MUL, 4'd11, 4'd2, 4'd10};
      5'd14:   ins = {OP_ADD, 4'd0,  4'd0, 4'd11};
      5'd15:   ins = {OP_MUL, 4'd11, 4'd3, 4'd10};
      5'd16:   ins = {OP_ADD, 4'd1,  4'd1, 4'd11};
      default: ins = {OP_ADD, 4'd0,  4'd0, 4'd0};
    endcase
    return ins;
  endfunction

  state_t              state_q, state_d;
  logic [4:0]          pc_q, pc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   nsteps_q, nsteps_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pos_q, pos_d;
  logic                op_valid_q, op_valid_d;
  logic [1:0]          op_code_q, op_code_d;
  logic [3:0]          op_a_q, op_a_d;
  logic [3:0]          op_b_q, op_b_d;
  logic                wr_en_q, wr_en_d;
  logic [3:0]          wr_addr_q, wr_addr_d;
  logic [STEP_W-1:0]   step_inc;
  instr_t              ins_d;

  assign step_inc = step_q + STEP_ONE;

  // Next-state and next-output logic; outputs are derived from the next state
  // so every output leaves a flop and is valid in the cycle of its state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    step_d   = step_q;
    nsteps_d = nsteps_q;
    to_d     = to_q;
    error_d  = error_q;
    done_d   = 1'b0;
    pos_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            error_d  = 1'b0;
            nsteps_d = num_steps;
            step_d   = '0;
            pc_d     = 5'd0;
            if (num_steps != '0) begin
              state_d = S_ISSUE;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        S_ISSUE: begin
          if (op_ready) begin
            state_d = S_WAIT;
            to_d    = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            state_d = S_WRITE;
          end else if (to_q == TO_LAST) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            to_d = to_q + TO_ONE;
          end
        end
        S_WRITE: begin
          if (pc_q == LAST_PC) begin
            // step_idx advances as STEP_END is entered; done rides with it
            state_d = S_STEP_END;
            step_d  = step_inc;
            pos_d   = 1'b1;
            done_d  = (step_inc == nsteps_q);
          end else begin
            state_d = S_ISSUE;
            pc_d    = pc_q + 5'd1;
          end
        end
        S_STEP_END: begin
          if (step_q == nsteps_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_ISSUE;
            pc_d    = 5'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    ins_d      = prog_rom(pc_d);
    busy_d     = (state_d != S_IDLE) && (state_d != S_ERR);
    op_valid_d = (state_d == S_ISSUE);
    wr_en_d    = (state_d == S_WRITE);
    if (op_valid_d) begin
      op_code_d = ins_d.op;
      op_a_d    = ins_d.a;
      op_b_d    = ins_d.b;
    end else begin
      op_code_d = 2'd0;
      op_a_d    = 4'd0;
      op_b_d    = 4'd0;
    end
    if (wr_en_d) begin
      wr_addr_d = ins_d.dst;
    end else begin
      wr_addr_d = 4'd0;
    end
  end

  // State, sequencing counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= 5'd0;
      step_q     <= '0;
      nsteps_q   <= '0;
      to_q       <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pos_q      <= 1'b0;
      op_valid_q <= 1'b0;
      op_code_q  <= 2'd0;
      op_a_q     <= 4'd0;
      op_b_q     <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      step_q     <= step_d;
      nsteps_q   <= nsteps_d;
      to_q       <= to_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pos_q      <= pos_d;
      op_valid_q <= op_valid_d;
      op_code_q  <= op_code_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign op_valid   = op_valid_q;
  assign op_code    = op_code_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign step_idx   = step_q;
  assign pos_strobe = pos_q;

endmodule

// File: tb/tb_orbit_step_ctrl.sv
// Directed testbench for orbit_step_ctrl. A negedge-side ALU model answers
// operations (ready high, result one cycle after accept) and logs activity;
// the test tasks drive start/abort/reset and compare against hand tables.
module tb_orbit_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_steps = 16'd0;
  logic        abort = 1'b0;
  logic        busy, done, error, op_valid, wr_en, pos_strobe;
  logic        op_ready = 1'b1;
  logic        res_valid = 1'b0;
  logic [1:0]  op_code;
  logic [3:0]  op_a, op_b, wr_addr;
  logic [15:0] step_idx;

  orbit_step_ctrl #(.STEP_W(16), .TIMEOUT(255), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps), .abort(abort),
    .busy(busy), .done(done), .error(error), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .step_idx(step_idx), .pos_strobe(pos_strobe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int exp_op  [17] = '{2, 2, 0, 3, 2, 2, 2, 2, 2, 2, 1, 2, 1, 2, 0, 2, 0};
  int exp_a   [17] = '{0, 1, 5, 4, 6, 5, 6, 0, 1, 7, 2, 8, 3, 2, 0, 3, 1};
  int exp_b   [17] = '{0, 1, 11, 4, 6, 6, 9, 5, 5, 10, 11, 10, 11, 10, 11, 10, 11};
  int exp_dst [17] = '{5, 11, 4, 6, 5, 6, 5, 7, 8, 11, 2, 11, 3, 11, 0, 11, 1};

  // Model state (written only by the model process).
  int nops = 0, nwr = 0, npos = 0, ndone = 0, nbusy = 0, nvalid = 0, done_ok = 0;
  int stall_samples = 0, stall_bad = 0, stall_cnt = 0, wait_cnt = 0;
  int acc_idx = -1;
  bit acc_pend = 1'b0;
  logic       prev_wr = 1'b0;
  logic [3:0] prev_wa = 4'd0;
  logic [1:0] ref_code = 2'd0;
  logic [3:0] ref_a = 4'd0, ref_b = 4'd0;
  int log_op [512], log_a [512], log_b [512], log_wr [512];

  // Knobs (written only by the test tasks).
  int stall_at = -1, stall_len = 0, wh_at = -1;
  bit spur = 1'b0;

  // ALU/register-file model and activity log, evaluated mid-cycle.
  always @(negedge clk) begin
    res_valid = (acc_pend && acc_idx != wh_at) || spur;
    acc_pend = 1'b0;
    if (busy === 1'b1 && wh_at >= 0 && acc_idx == wh_at && op_valid === 1'b0 && wr_en === 1'b0)
      wait_cnt++;
    if (op_valid === 1'b1) nvalid++;
    if (busy === 1'b1) nbusy++;
    if (pos_strobe === 1'b1) npos++;
    if (done === 1'b1) begin
      ndone++;
      if (pos_strobe === 1'b1 && prev_wr === 1'b1 && prev_wa == 4'd1) done_ok++;
    end
    if (wr_en === 1'b1) begin
      if (nwr < 512) log_wr[nwr] = int'(wr_addr);
      nwr++;
    end
    prev_wr = wr_en;
    prev_wa = wr_addr;
    if (nops != stall_at) stall_cnt = 0;
    if (op_valid === 1'b1 && nops == stall_at && stall_cnt < stall_len) begin
      if (stall_cnt == 0) begin
        ref_code = op_code; ref_a = op_a; ref_b = op_b;
      end
      op_ready = 1'b0;
      stall_cnt++;
      stall_samples++;
      if (op_code !== ref_code || op_a !== ref_a || op_b !== ref_b) stall_bad++;
    end else begin
      op_ready = 1'b1;
    end
    if (op_valid === 1'b1 && op_ready === 1'b1) begin
      if (nops < 512) begin
        log_op[nops] = int'(op_code); log_a[nops] = int'(op_a); log_b[nops] = int'(op_b);
      end
      acc_idx = nops;
      acc_pend = 1'b1;
      nops++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    num_steps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, error, op_valid, op_code, op_a, op_b, wr_en, wr_addr, step_idx, pos_strobe} !== 39'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0",
        {busy, done, error, op_valid, op_code, op_a, op_b, wr_en, wr_addr, step_idx, pos_strobe});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    tests++;
    if ({busy, done, error, op_valid, wr_en, pos_strobe} !== 6'd0 || step_idx !== 16'd0) begin
      fails++; $display("FAIL idle_after_reset: got busy=%b done=%b err=%b step=%0d expected all 0",
        busy, done, error, step_idx);
    end
  endtask

  task automatic test_single_step();
    int b_ops = nops, b_wr = nwr, b_busy = nbusy, b_pos = npos, b_done = ndone, b_dok = done_ok;
    int bad_op = -1, bad_wr = -1;
    bit ok;
    do_start(16'd1);
    wait_idle(200, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL single_timeout: got busy=%b expected 0", busy); end
    tests++;
    if (nops - b_ops != 17) begin fails++; $display("FAIL single_ops: got %0d expected 17", nops - b_ops); end
    for (int i = 16; i >= 0; i--) begin
      if (log_op[b_ops+i] != exp_op[i] || log_a[b_ops+i] != exp_a[i] || log_b[b_ops+i] != exp_b[i]) bad_op = i;
      if (log_wr[b_wr+i] != exp_dst[i]) bad_wr = i;
    end
    tests++;
    if (bad_op != -1) begin fails++; $display("FAIL single_op_seq: first bad pc %0d got op=%0d a=%0d b=%0d expected op=%0d a=%0d b=%0d",
      bad_op, log_op[b_ops+bad_op], log_a[b_ops+bad_op], log_b[b_ops+bad_op], exp_op[bad_op], exp_a[bad_op], exp_b[bad_op]); end
    tests++;
    if (bad_wr != -1) begin fails++; $display("FAIL single_wr_seq: first bad pc %0d got %0d expected %0d",
      bad_wr, log_wr[b_wr+bad_wr], exp_dst[bad_wr]); end
    tests++;
    if (nbusy - b_busy != 52) begin fails++; $display("FAIL single_busy_cycles: got %0d expected 52", nbusy - b_busy); end
    tests++;
    if (npos - b_pos != 1) begin fails++; $display("FAIL single_pos: got %0d expected 1", npos - b_pos); end
    tests++;
    if (ndone - b_done != 1) begin fails++; $display("FAIL single_done: got %0d expected 1", ndone - b_done); end
    tests++;
    if (done_ok - b_dok != 1) begin fails++; $display("FAIL single_done_timing: got %0d expected 1", done_ok - b_dok); end
    tests++;
    if (step_idx !== 16'd1) begin fails++; $display("FAIL single_step_idx: got %0d expected 1", step_idx); end
  endtask

  task automatic test_stall();
    int b_ops = nops, b_busy = nbusy, b_pos = npos, b_done = ndone, b_ss = stall_samples, b_sb = stall_bad;
    bit ok;
    stall_at = b_ops + 20;
    stall_len = 4;
    do_start(16'd3);
    wait_idle(400, ok);
    stall_at = -1;
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL stall_timeout: got busy=%b expected 0", busy); end
    tests++;
    if (stall_samples - b_ss != 4) begin fails++; $display("FAIL stall_cycles: got %0d expected 4", stall_samples - b_ss); end
    tests++;
    if (stall_bad - b_sb != 0) begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad - b_sb); end
    tests++;
    if (log_op[b_ops+20] != 3 || log_a[b_ops+20] != 4 || log_b[b_ops+20] != 4) begin fails++;
      $display("FAIL stall_op: got op=%0d a=%0d b=%0d expected op=3 a=4 b=4", log_op[b_ops+20], log_a[b_ops+20], log_b[b_ops+20]); end
    tests++;
    if (nops - b_ops != 51) begin fails++; $display("FAIL stall_ops: got %0d expected 51", nops - b_ops); end
    tests++;
    if (nbusy - b_busy != 160) begin fails++; $display("FAIL stall_busy_cycles: got %0d expected 160", nbusy - b_busy); end
    tests++;
    if (npos - b_pos != 3) begin fails++; $display("FAIL stall_pos: got %0d expected 3", npos - b_pos); end
    tests++;
    if (ndone - b_done != 1) begin fails++; $display("FAIL stall_done: got %0d expected 1", ndone - b_done); end
    tests++;
    if (step_idx !== 16'd3) begin fails++; $display("FAIL stall_step_idx: got %0d expected 3", step_idx); end
  endtask

  task automatic test_timeout();
    int b_ops = nops, b_wr = nwr, b_wc = wait_cnt, b_done, b_val;
    bit ok = 1'b0;
    wh_at = b_ops + 7;
    do_start(16'd2);
    for (int i = 0; i < 600; i++) begin
      if (error === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL to_error_seen: got error=%b expected 1", error); end
    tests++;
    if (wait_cnt - b_wc != 255) begin fails++; $display("FAIL to_wait_cycles: got %0d expected 255", wait_cnt - b_wc); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b expected 0", busy); end
    tests++;
    if (nwr - b_wr != 7) begin fails++; $display("FAIL to_writes: got %0d expected 7", nwr - b_wr); end
    tests++;
    if (step_idx !== 16'd0) begin fails++; $display("FAIL to_step_idx: got %0d expected 0", step_idx); end
    b_val = nvalid;
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (nvalid - b_val != 0 || error !== 1'b1) begin fails++;
      $display("FAIL to_err_quiet: got %0d op_valid cycles error=%b expected 0 and 1", nvalid - b_val, error); end
    wh_at = -1;
    b_done = ndone;
    do_start(16'd1);
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL to_restart: got error=%b busy=%b expected 0 1", error, busy); end
    wait_idle(200, ok);
    tests++;
    if (ok !== 1'b1 || ndone - b_done != 1) begin fails++;
      $display("FAIL to_rerun_done: got %0d done (idle=%b) expected 1", ndone - b_done, ok); end
  endtask

  task automatic test_abort();
    int b_ops = nops, b_wr = nwr, b_done = ndone, b2, bad = -1;
    bit found = 1'b0, ok;
    do_start(16'd2);
    for (int i = 0; i < 100; i++) begin
      if (res_valid === 1'b1 && nops == b_ops + 5) begin found = 1'b1; break; end
      tick();
    end
    tests++;
    if (found !== 1'b1) begin fails++; $display("FAIL abort_setup: got nops=%0d expected %0d", nops - b_ops, 5); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if ({busy, op_valid, wr_en} !== 3'b000) begin fails++;
      $display("FAIL abort_idle: got busy/op_valid/wr_en=%b expected 000", {busy, op_valid, wr_en}); end
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (nwr - b_wr != 4) begin fails++; $display("FAIL abort_writes: got %0d expected 4", nwr - b_wr); end
    tests++;
    if (ndone - b_done != 0 || step_idx !== 16'd0) begin fails++;
      $display("FAIL abort_no_done: got done=%0d step=%0d expected 0 0", ndone - b_done, step_idx); end
    b2 = nops;
    b_done = ndone;
    do_start(16'd1);
    wait_idle(200, ok);
    for (int i = 16; i >= 0; i--)
      if (log_op[b2+i] != exp_op[i] || log_a[b2+i] != exp_a[i] || log_b[b2+i] != exp_b[i]) bad = i;
    tests++;
    if (bad != -1 || nops - b2 != 17) begin fails++;
      $display("FAIL abort_rerun_seq: got first bad pc %0d ops=%0d expected -1 17", bad, nops - b2); end
    tests++;
    if (ndone - b_done != 1 || step_idx !== 16'd1) begin fails++;
      $display("FAIL abort_rerun_done: got done=%0d step=%0d expected 1 1", ndone - b_done, step_idx); end
  endtask

  task automatic test_zero_and_ignored_start();
    int b_done = ndone, b_val = nvalid, b_pos, b_busy;
    bit ok;
    do_start(16'd0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy); end
    tick();
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (nvalid - b_val != 0 || ndone - b_done != 1) begin fails++;
      $display("FAIL zero_no_ops: got valid=%0d done=%0d expected 0 1", nvalid - b_val, ndone - b_done); end
    b_done = ndone; b_pos = npos; b_busy = nbusy;
    do_start(16'd2);
    for (int i = 0; i < 30; i++) tick();
    do_start(16'd5);
    wait_idle(300, ok);
    tests++;
    if (npos - b_pos != 2 || step_idx !== 16'd2) begin fails++;
      $display("FAIL ignored_start_steps: got pos=%0d step=%0d expected 2 2", npos - b_pos, step_idx); end
    tests++;
    if (ndone - b_done != 1 || nbusy - b_busy != 104) begin fails++;
      $display("FAIL ignored_start_done: got done=%0d busy=%0d expected 1 104", ndone - b_done, nbusy - b_busy); end
  endtask

  task automatic test_spurious_and_reset();
    int b_wr = nwr;
    bit found = 1'b0;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    spur = 1'b0;
    tick(); tick();
    tests++;
    if (nwr - b_wr != 0 || busy !== 1'b0) begin fails++;
      $display("FAIL spur_idle: got writes=%0d busy=%b expected 0 0", nwr - b_wr, busy); end
    stall_at = nops;
    stall_len = 4;
    do_start(16'd1);
    spur = 1'b1;
    tick(); tick();
    spur = 1'b0;
    tick(); tick();
    tests++;
    if (nwr - b_wr != 0) begin fails++; $display("FAIL spur_issue: got writes=%0d expected 0", nwr - b_wr); end
    for (int i = 0; i < 20; i++) begin
      if (wr_en === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    stall_at = -1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (found !== 1'b1 || nwr - b_wr != 1 || log_wr[b_wr] != 5) begin fails++;
      $display("FAIL spur_first_write: got found=%b writes=%0d addr=%0d expected 1 1 5", found, nwr - b_wr, log_wr[b_wr]); end
    tests++;
    if ({busy, done, error, op_valid, op_code, op_a, op_b, wr_en, wr_addr, step_idx, pos_strobe} !== 39'd0) begin
      fails++; $display("FAIL reset_mid_write: got %h expected 0",
        {busy, done, error, op_valid, op_code, op_a, op_b, wr_en, wr_addr, step_idx, pos_strobe});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (busy !== 1'b0 || nwr - b_wr != 1) begin fails++;
      $display("FAIL after_reset_quiet: got busy=%b writes=%0d expected 0 1", busy, nwr - b_wr); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_stall();
    test_timeout();
    test_abort();
    test_zero_and_ignored_start();
    test_spurious_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
